// File: rtl/code_mask_pkg.sv
// Shared encoding for the code/mask conversion blocks (this decoder and the
// matching serial priority encoder).
package code_mask_pkg;

    localparam int DEFAULT_CODE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/binary_to_onehot.sv
// Combinational binary index to one-hot decoder.
module binary_to_onehot #(
    parameter int CODE_W = 2
) (
    input  logic [CODE_W-1:0]      code,
    output logic [(2**CODE_W)-1:0] onehot
);

    // One line per index; exactly one compares equal
    always_comb begin
        onehot = '0;
        for (int i = 0; i < 2**CODE_W; i++) begin
            if (code == CODE_W'(i)) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/code_to_mask_decoder.sv
// Collects a group of binary codes into an OR-ed one-hot mask with a
// saturating beat count and a sticky duplicate flag; presents it for one handshake.
module code_to_mask_decoder
    import code_mask_pkg::*;
#(
    parameter int CODE_W = DEFAULT_CODE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CODE_W-1:0]       in_code,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(2**CODE_W)-1:0]  out_mask,
    output logic [CODE_W:0]         out_count,
    output logic                    out_dup
);

    localparam int MASK_W = 2**CODE_W;

    state_t              state_r;
    state_t              state_next_s;
    logic [MASK_W-1:0]   mask_r;
    logic [CODE_W:0]     count_r;
    logic                dup_r;
    logic                in_ready_r;
    logic                out_valid_r;

    logic [MASK_W-1:0]   onehot_s;
    logic                accept_s;
    logic                consume_s;
    logic                count_sat_s;

    binary_to_onehot #(
        .CODE_W (CODE_W)
    ) u_decode (
        .code   (in_code),
        .onehot (onehot_s)
    );

    assign accept_s    = in_valid && in_ready_r;
    assign consume_s   = out_valid_r && out_ready;
    assign count_sat_s = (count_r == {(CODE_W+1){1'b1}});

    // Next-state selection
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && in_last) begin
                    state_next_s = ST_HOLD;
                end else if (accept_s) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && in_last) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; handshake flags are decoded from the next state so
    // they are flops that always match the registered state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_HOLD);
            out_valid_r <= (state_next_s == ST_HOLD);
        end
    end

    // Group accumulators: cleared on consume, updated on every accepted beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r  <= '0;
            count_r <= '0;
            dup_r   <= 1'b0;
        end else if (consume_s) begin
            mask_r  <= '0;
            count_r <= '0;
            dup_r   <= 1'b0;
        end else if (accept_s) begin
            mask_r  <= mask_r | onehot_s;
            count_r <= count_sat_s ? count_r : (count_r + {{CODE_W{1'b0}}, 1'b1});
            dup_r   <= dup_r || ((mask_r & onehot_s) != '0);
        end else begin
            mask_r  <= mask_r;
            count_r <= count_r;
            dup_r   <= dup_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_mask  = mask_r;
    assign out_count = count_r;
    assign out_dup   = dup_r;

endmodule

// File: tb/tb_code_to_mask_decoder.sv
// Directed-vector bench for code_to_mask_decoder with hand-computed expectations.
`timescale 1ns/1ps
module tb_code_to_mask_decoder;

    localparam int CODE_W = 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_mask;
    logic [2:0]        out_count;
    logic              out_dup;

    int total;
    int bad;

    code_to_mask_decoder #(
        .CODE_W (CODE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one beat on a falling edge, hold it across one rising edge, sample #1 after
    task automatic beat(input logic [1:0] code, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = code;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] m,
                             input logic [2:0] c, input logic d);
        check_val({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        check_val({tag, "_ready"}, {31'd0, in_ready}, {31'd0, ~v});
        check_val({tag, "_mask"},  {28'd0, out_mask}, {28'd0, m});
        check_val({tag, "_count"}, {29'd0, out_count}, {29'd0, c});
        check_val({tag, "_dup"},   {31'd0, out_dup},  {31'd0, d});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_out("reset", 1'b0, 4'b0000, 3'd0, 1'b0);

        // Codes 3,1(last), consumer always ready
        beat(2'd3, 1'b0);
        check_out("g1_mid", 1'b0, 4'b1000, 3'd1, 1'b0);
        beat(2'd1, 1'b1);
        check_out("g1_hold", 1'b1, 4'b1010, 3'd2, 1'b0);
        idle_cycle();
        check_out("g1_done", 1'b0, 4'b0000, 3'd0, 1'b0);

        // in_last without in_valid must not start a group
        @(negedge clk);
        in_last = 1'b1;
        in_code = 2'd2;
        idle_cycle();
        in_last = 1'b0;
        check_out("novalid", 1'b0, 4'b0000, 3'd0, 1'b0);

        // Single-beat group
        beat(2'd0, 1'b1);
        check_out("single", 1'b1, 4'b0001, 3'd1, 1'b0);
        idle_cycle();

        // Duplicate within group, then dup clear on the next group
        beat(2'd2, 1'b0);
        beat(2'd2, 1'b0);
        check_out("dup_mid", 1'b0, 4'b0100, 3'd2, 1'b1);
        beat(2'd0, 1'b1);
        check_out("dup_hold", 1'b1, 4'b0101, 3'd3, 1'b1);
        idle_cycle();
        beat(2'd1, 1'b1);
        check_out("after_dup", 1'b1, 4'b0010, 3'd1, 1'b0);
        idle_cycle();

        // Backpressure: hold group with in_valid pending
        @(negedge clk);
        out_ready = 1'b0;
        beat(2'd0, 1'b0);
        beat(2'd1, 1'b0);
        beat(2'd2, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 2'd3;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            check_out("stall", 1'b1, 4'b0111, 3'd3, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        idle_cycle();
        check_out("release", 1'b0, 4'b0000, 3'd0, 1'b0);
        idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_out("pending_beat", 1'b1, 4'b1000, 3'd1, 1'b0);
        idle_cycle();

        // Reset mid-group discards it; first edge after release accepts
        beat(2'd3, 1'b0);
        beat(2'd2, 1'b0);
        check_out("pre_rst", 1'b0, 4'b1100, 3'd2, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_async_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_async_mask", {28'd0, out_mask}, 32'd0);
        check_val("rst_async_count", {29'd0, out_count}, 32'd0);
        idle_cycle();
        check_val("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_code  = 2'd1;
        in_last  = 1'b1;
        idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_out("post_rst", 1'b1, 4'b0010, 3'd1, 1'b0);
        idle_cycle();

        // Count saturation: 8 non-last beats then last
        for (int i = 0; i < 8; i++) begin
            beat(2'(i % 4), 1'b0);
            if (i == 6) check_out("sat7", 1'b0, 4'b1111, 3'd7, 1'b1);
        end
        check_out("sat8", 1'b0, 4'b1111, 3'd7, 1'b1);
        beat(2'd1, 1'b1);
        check_out("sat9", 1'b1, 4'b1111, 3'd7, 1'b1);
        idle_cycle();
        check_out("sat_done", 1'b0, 4'b0000, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
